// File: rtl/pattern_mem_pkg.sv
// Shared definitions for the per-channel pattern memory controller.
// Holds the control-byte bit indices (shared with the GPIO op decoder) and the FSM encoding.
// Optional feature macro: PATTERN_MEM_SYNC_EN (see ctrl_edge_detect).
package pattern_mem_pkg;

    localparam int unsigned CTRL_W         = 8;
    localparam int unsigned CTRL_WR        = 0;
    localparam int unsigned CTRL_SET_ADDR  = 1;
    localparam int unsigned CTRL_NEXT_ADDR = 2;
    localparam int unsigned CTRL_PLAY_EN   = 3;
    localparam int unsigned CTRL_WEN       = 4;
    localparam int unsigned CTRL_MODE      = 5;
    localparam int unsigned CTRL_DIN       = 6;
    localparam int unsigned CTRL_DOUT_EN   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ctrl_edge_detect.sv
// Control-byte front end: optional 2-FF synchronizer, then rising-edge pulses for
// wr / set_addr / next_addr and pass-through of the level-type control bits.
// Macro: PATTERN_MEM_SYNC_EN adds the synchronizer (2 extra cycles of latency).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ctrl              packed control byte from the op decoder
//   *_ev_c            single-cycle events on a 0->1 transition (combinational)
//   *_c (levels)      control levels after the optional sync stage (combinational)
module ctrl_edge_detect
    import pattern_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              wr_ev_c,
    output logic              set_addr_ev_c,
    output logic              next_addr_ev_c,
    output logic              play_en_c,
    output logic              wen_c,
    output logic              mode_c,
    output logic              din_c,
    output logic              dout_en_c
);

    logic [CTRL_W-1:0] ctrl_s;
    logic [2:0]        evt_q;

`ifdef PATTERN_MEM_SYNC_EN
    logic [CTRL_W-1:0] sync_q1;
    logic [CTRL_W-1:0] sync_q2;

    // Two-flop synchronizer for an asynchronous control source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= ctrl;
            sync_q2 <= sync_q1;
        end
    end
    assign ctrl_s = sync_q2;
`else
    assign ctrl_s = ctrl;
`endif

    // Previous value of the edge-type bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= {ctrl_s[CTRL_NEXT_ADDR], ctrl_s[CTRL_SET_ADDR], ctrl_s[CTRL_WR]};
        end
    end

    assign wr_ev_c        = ctrl_s[CTRL_WR]        & ~evt_q[0];
    assign set_addr_ev_c  = ctrl_s[CTRL_SET_ADDR]  & ~evt_q[1];
    assign next_addr_ev_c = ctrl_s[CTRL_NEXT_ADDR] & ~evt_q[2];

    assign play_en_c = ctrl_s[CTRL_PLAY_EN];
    assign wen_c     = ctrl_s[CTRL_WEN];
    assign mode_c    = ctrl_s[CTRL_MODE];
    assign din_c     = ctrl_s[CTRL_DIN];
    assign dout_en_c = ctrl_s[CTRL_DOUT_EN];

endmodule

// File: rtl/pattern_mem_ctrl.sv
// Per-channel pattern memory controller: records 1-bit samples into an internal
// memory and plays them back as a serial stream, one-shot or looping.
// Macro: PATTERN_MEM_SYNC_EN synchronizes ctrl before use.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ctrl          {dout_en,din,mode,wen,play_en,next_addr,set_addr,wr}
//   pattern_out   playback bit gated by dout_en
//   playing       FSM in PLAY
//   done          one-shot playback finished
//   cur_addr      write/edit pointer
//   length        number of valid entries (high-water mark)
module pattern_mem_ctrl
    import pattern_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              pattern_out,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W:0]   length
);

    localparam int unsigned LEN_W    = ADDR_W + 1;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic wr_ev, set_addr_ev, next_addr_ev;
    logic play_en, wen, mode, din, dout_en;

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [DIV_W-1:0]  div_cnt;
    logic              loop_q;
    logic              mem [DEPTH];

    ctrl_edge_detect u_edge (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl           (ctrl),
        .wr_ev_c        (wr_ev),
        .set_addr_ev_c  (set_addr_ev),
        .next_addr_ev_c (next_addr_ev),
        .play_en_c      (play_en),
        .wen_c          (wen),
        .mode_c         (mode),
        .din_c          (din),
        .dout_en_c      (dout_en)
    );

    // Pattern storage; edits are only accepted while idle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr_ev && wen) begin
            mem[cur_addr] <= din;
        end
    end

    // Control FSM, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pattern_out <= 1'b0;
            playing     <= 1'b0;
            done        <= 1'b0;
            cur_addr    <= '0;
            length      <= '0;
            ptr         <= '0;
            div_cnt     <= '0;
            loop_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pattern_out <= 1'b0;
                    // wr sees cur_addr before this cycle's pointer update
                    if (wr_ev && wen && (LEN_W'(cur_addr) >= length)) begin
                        length <= LEN_W'(cur_addr) + LEN_W'(1);
                    end
                    if (set_addr_ev) begin
                        cur_addr <= '0;
                        if (wen) begin
                            length <= '0;
                        end
                    end else if (next_addr_ev) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                    end
                    if (play_en) begin
                        if (length != '0) begin
                            state   <= ST_PLAY;
                            playing <= 1'b1;
                            loop_q  <= mode;
                            ptr     <= '0;
                            div_cnt <= '0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (!play_en) begin
                        state       <= ST_IDLE;
                        playing     <= 1'b0;
                        pattern_out <= 1'b0;
                    end else begin
                        pattern_out <= mem[ptr] & dout_en;
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (LEN_W'(ptr) == length - LEN_W'(1)) begin
                                ptr <= '0;
                                if (!loop_q) begin
                                    state   <= ST_DONE;
                                    playing <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end else begin
                                ptr <= ptr + ADDR_W'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    pattern_out <= 1'b0;
                    if (!play_en) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_mem_ctrl.sv
// Directed self-checking bench for pattern_mem_ctrl (DEPTH=16, CLK_DIV=3).
module tb_pattern_mem_ctrl;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned CLK_DIV = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dout_en = 1'b0, din = 1'b0, mode = 1'b0, wen = 1'b0;
    logic              play_en = 1'b0, next_addr = 1'b0, set_addr = 1'b0, wr = 1'b0;
    logic [7:0]        ctrl;
    logic              pattern_out, playing, done;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   length;

    int vec_cnt  = 0;
    int miscmp   = 0;

    logic [3:0]  pat  = 4'b1101;          // bit i = sample at address i -> 1,0,1,1
    logic [11:0] loop_exp = 12'b111111000111; // bit k = expected output k

    assign ctrl = {dout_en, din, mode, wen, play_en, next_addr, set_addr, wr};

    always #5 clk = ~clk;

    pattern_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl        (ctrl),
        .pattern_out (pattern_out),
        .playing     (playing),
        .done        (done),
        .cur_addr    (cur_addr),
        .length      (length)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_set();
        set_addr = 1'b1; tick();
        set_addr = 1'b0; tick();
    endtask

    task automatic pulse_next();
        next_addr = 1'b1; tick();
        next_addr = 1'b0; tick();
    endtask

    task automatic pulse_wr(input logic d);
        din = d;
        wr = 1'b1; tick();
        wr = 1'b0; tick();
    endtask

    // Start a new pattern and write 1,0,1,1 at addresses 0..3.
    task automatic write_pattern();
        wen = 1'b1;
        pulse_set();
        for (int i = 0; i < 4; i++) begin
            pulse_wr(pat[i]);
            if (i < 3) pulse_next();
        end
    endtask

    initial begin
        // reset state
        #2;
        check("rst_pattern_out", 32'(pattern_out), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        check("rst_length", 32'(length), 32'd0);
        tick();
        rst_n = 1'b1;
        dout_en = 1'b1;
        tick();

        // 1: write pattern
        write_pattern();
        check("t1_length", 32'(length), 32'd4);
        check("t1_cur_addr", 32'(cur_addr), 32'd3);

        // 2: wr held high writes once only
        pulse_next();
        din = 1'b0;
        wr = 1'b1;
        repeat (20) tick();
        wr = 1'b0;
        tick();
        check("t2_length", 32'(length), 32'd5);
        check("t2_cur_addr", 32'(cur_addr), 32'd4);
        write_pattern();
        check("t2_relength", 32'(length), 32'd4);

        // 3: looping playback
        mode = 1'b1; play_en = 1'b1;
        tick();
        check("t3_playing", 32'(playing), 32'd1);
        for (int k = 0; k < 24; k++) begin
            tick();
            check($sformatf("t3_sample%0d", k), 32'(pattern_out), 32'(loop_exp[k % 12]));
        end
        play_en = 1'b0;
        tick();
        check("t3_stop_playing", 32'(playing), 32'd0);
        check("t3_stop_out", 32'(pattern_out), 32'd0);

        // 4: one-shot playback
        mode = 1'b0; play_en = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("t4_sample%0d", k), 32'(pattern_out), 32'(loop_exp[k]));
        end
        tick();
        check("t4_done", 32'(done), 32'd1);
        check("t4_out", 32'(pattern_out), 32'd0);
        check("t4_playing", 32'(playing), 32'd0);
        tick();
        check("t4_done_hold", 32'(done), 32'd1);
        play_en = 1'b0;
        tick();
        check("t4_done_clr", 32'(done), 32'd0);

        // 5: empty pattern goes straight to done; pointer wrap
        wen = 1'b1;
        pulse_set();
        check("t5_length0", 32'(length), 32'd0);
        play_en = 1'b1;
        tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_playing", 32'(playing), 32'd0);
        tick();
        check("t5_playing_hold", 32'(playing), 32'd0);
        play_en = 1'b0;
        tick();
        check("t5_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) pulse_next();
        check("t5_addr_max", 32'(cur_addr), 32'(DEPTH - 1));
        pulse_next();
        check("t5_addr_wrap", 32'(cur_addr), 32'd0);

        // 6: edits ignored during playback, dout_en gating, async reset
        write_pattern();
        mode = 1'b1; play_en = 1'b1;
        tick();
        pulse_set();
        pulse_wr(1'b0);
        check("t6_cur_addr", 32'(cur_addr), 32'd3);
        check("t6_length", 32'(length), 32'd4);
        play_en = 1'b0;
        tick();
        play_en = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("t6_sample%0d", k), 32'(pattern_out), 32'(loop_exp[k]));
        end
        dout_en = 1'b0;
        tick();
        check("t6_gate0", 32'(pattern_out), 32'd0);
        check("t6_gate_playing", 32'(playing), 32'd1);
        dout_en = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 32'(pattern_out), 32'd0);
        check("t6_rst_playing", 32'(playing), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_cur_addr", 32'(cur_addr), 32'd0);
        check("t6_rst_length", 32'(length), 32'd0);
        play_en = 1'b0; mode = 1'b0; wen = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
